psram_req_arbiter: RTL
======================

// Module: psram_req_arbiter
// PURPOSE
//  Shares the single QSPI PSRAM port of the cnn_kws_accel among three requesters:
//  audio sample writer (0), CNN weight/activation fetcher (1) and host debug port (2).
//  Selects one request, issues one burst command to the PSRAM controller, waits for
//  completion or timeout, then returns completion to the winner. Sits between the
//  accelerator datapath clients and the PSRAM serial engine, in the clk domain.
// PARAMETERS
//  NREQ      3     number of requesters (index 0 = strict priority)
//  ADDR_W    24    PSRAM byte address width
//  LEN_W     8     burst length field; value = beats-1
//  TIMEOUT   1023  max cycles in BUSY before forced abort
// PORTS
//  clk           in   1              accelerator clock
//  rst           in   1              asynchronous reset, active-high
//  req_i         in   NREQ           request, held until gnt_o of that index
//  req_we_i      in   NREQ           1=write, 0=read, per requester
//  req_addr_i    in   NREQ*ADDR_W    flattened start addresses
//  req_len_i     in   NREQ*LEN_W     flattened burst lengths (beats-1)
//  gnt_o         out  NREQ           one-cycle grant pulse, one-hot
//  done_o        out  NREQ           one-cycle completion pulse to granted requester
//  err_o         out  1              pulses with done_o when transfer timed out
//  busy_o        out  1              1 from ISSUE through end of BUSY
//  mem_start_o   out  1              one-cycle command strobe to PSRAM controller
//  mem_we_o      out  1              latched direction
//  mem_addr_o    out  ADDR_W         latched address
//  mem_len_o     out  LEN_W          latched length
//  mem_done_i    in   1              one-cycle completion from PSRAM controller
//  perf_cnt_o    out  NREQ*16+16     performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 1, timeout counter 0.
//  FSM IDLE -> ISSUE -> BUSY -> IDLE.
//  IDLE: if any req_i, pick winner: req_i[0] wins unconditionally; else round-robin
//   over 1..NREQ-1 starting at rr pointer. Latch we/addr/len/index; go ISSUE.
//  ISSUE (1 cycle): mem_start_o=1 and gnt_o[w]=1 same cycle; rr pointer advances past w
//   only if w!=0; clear timeout counter; go BUSY.
//  BUSY: count cycles; mem_done_i -> done_o[w]=1, go IDLE. Counter reaching TIMEOUT
//   without mem_done_i -> done_o[w]=1 and err_o=1, go IDLE. Both same cycle: done wins, err_o=0.
//  Latency: req_i rise in IDLE -> gnt_o/mem_start_o 1 cycle later; done_o 1 cycle after
//   mem_done_i. Back-to-back: next arbitration occurs in IDLE cycle after done_o.
//  mem_addr/we/len_o hold latched values from ISSUE until next ISSUE (stable in BUSY).
//  req_i dropped before grant: withdrawn, no grant. req_i held after gnt_o: new request.
//  mem_done_i in IDLE or ISSUE: ignored.
//  Requester 0 may starve 1..NREQ-1; by design (real-time audio).
//  rst asserted mid-transfer: immediate return to reset values; no done_o issued;
//   PSRAM controller shares rst and aborts likewise.
// CONFIGURATION
//  PSRAM_ARB_PERF_EN defined: perf_cnt_o = {timeout_cnt[15:0], gnt_cnt[NREQ-1..0][15:0]},
//   16-bit saturating counters, incremented on gnt_o / err_o, cleared only by rst.
//  Not defined: counters not built, perf_cnt_o tied to 0; all other behaviour identical.
// STRUCTURE
//  psram_arb_pkg: state enum (IDLE, ISSUE, BUSY), requester index constants
//   (REQ_AUDIO=0, REQ_CNN=1, REQ_HOST=2), default widths and TIMEOUT.
//  Sub-module psram_arb_pick: combinational priority + round-robin selector
//   (req vector, rr pointer -> one-hot winner, valid).
// TESTING
//  1. req_i=3'b010, addr 0x001000, len 15, read -> gnt_o=010 and mem_start_o 1 cycle later,
//     mem_addr_o=0x001000; mem_done_i after 40 cycles -> done_o=010 next cycle, err_o=0.
//  2. req_i=3'b111 held continuously -> grant order 0,0,0... while req0 held; drop req0
//     -> grants alternate 1,2,1,2.
//  3. req_i=3'b110 from reset -> grants 1,2,1; rr pointer unaffected by interleaved req0 grant.
//  4. No mem_done_i for 1023 BUSY cycles -> done_o[w]=1 and err_o=1; with PSRAM_ARB_PERF_EN
//     timeout counter =1; mem_done_i on the 1023rd cycle instead -> err_o=0.
//  5. rst asserted 5 cycles into BUSY -> all outputs 0 same cycle, no done_o; after release
//     held req_i re-arbitrated normally.
//  6. Perf build: 70000 grants to requester 1 -> its counter saturates at 0xFFFF.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and defaults for the PSRAM request arbiter.
// Used by psram_arb_pick and psram_req_arbiter.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int REQ_AUDIO = 0;
    localparam int REQ_CNN   = 1;
    localparam int REQ_HOST  = 2;

    localparam int DEF_NREQ    = 3;
    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_TIMEOUT = 1023;

    localparam int PERF_W = 16;

    function automatic logic [PERF_W-1:0] sat_inc16(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational winner select: requester 0 has strict priority, the rest
// are served round-robin starting at the rr pointer.
module psram_arb_pick
    import psram_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    logic hit;

    always_comb begin
        win     = '0;
        win_idx = '0;
        hit     = 1'b0;
        valid   = |req;
        if (req[REQ_AUDIO]) begin
            win[REQ_AUDIO] = 1'b1;
            win_idx        = IDX_W'(REQ_AUDIO);
            hit            = 1'b1;
        end
        // first pass covers rr..NREQ-1, second pass wraps to 1..rr-1
        for (int k = 1; k < NREQ; k++) begin
            if (!hit && req[k] && (k >= int'(rr))) begin
                win[k]  = 1'b1;
                win_idx = IDX_W'(k);
                hit     = 1'b1;
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            if (!hit && req[k]) begin
                win[k]  = 1'b1;
                win_idx = IDX_W'(k);
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psram_req_arbiter.sv
// Shares the single PSRAM port among NREQ requesters, one burst at a time.
// Optional performance counters built when PSRAM_ARB_PERF_EN is defined.
module psram_req_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*LEN_W-1:0]    req_len_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic                     mem_start_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [LEN_W-1:0]         mem_len_o,
    input  logic                     mem_done_i,
    output logic [NREQ*16+15:0]      perf_cnt_o
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   win_idx_q;
    logic [NREQ-1:0]    win_q;
    logic [TCNT_W-1:0]  tcnt;
    logic               timeout_hit;

    logic [NREQ-1:0]    pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    psram_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_i),
        .rr      (rr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    // tcnt holds k-1 during the k-th BUSY cycle
    assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (mem_done_i || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = '0;
        mem_start_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            ISSUE: begin
                gnt_o       = win_q;
                mem_start_o = 1'b1;
                busy_o      = 1'b1;
            end
            BUSY:    busy_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr         <= IDX_W'(REQ_CNN);
            win_idx_q  <= '0;
            win_q      <= '0;
            tcnt       <= '0;
            done_o     <= '0;
            err_o      <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_len_o  <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win_q      <= pick_win;
                        win_idx_q  <= pick_idx;
                        mem_we_o   <= req_we_i[pick_idx];
                        mem_addr_o <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                        mem_len_o  <= req_len_i[pick_idx*LEN_W +: LEN_W];
                    end
                end
                ISSUE: begin
                    tcnt <= '0;
                    // audio grants leave the round-robin position untouched
                    if (win_idx_q != '0) begin
                        rr <= (win_idx_q == IDX_W'(NREQ - 1)) ? IDX_W'(REQ_CNN)
                                                              : win_idx_q + IDX_W'(1);
                    end
                end
                BUSY: begin
                    tcnt <= tcnt + TCNT_W'(1);
                    if (mem_done_i) begin
                        done_o <= win_q;
                    end else if (timeout_hit) begin
                        done_o <= win_q;
                        err_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PSRAM_ARB_PERF_EN
    logic [PERF_W-1:0] gnt_cnt [NREQ];
    logic [PERF_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) gnt_cnt[i] <= '0;
            tmo_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_o[i]) gnt_cnt[i] <= sat_inc16(gnt_cnt[i]);
            end
            if (err_o) tmo_cnt <= sat_inc16(tmo_cnt);
        end
    end

    always_comb begin
        perf_cnt_o = '0;
        for (int i = 0; i < NREQ; i++) perf_cnt_o[i*PERF_W +: PERF_W] = gnt_cnt[i];
        perf_cnt_o[NREQ*PERF_W +: PERF_W] = tmo_cnt;
    end
`else
    assign perf_cnt_o = '0;
`endif

endmodule
